// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner.
//   state_e     : scanner FSM states
//   COL_0..3    : active-low column strobe patterns, col_idx 0..3
//   ROWS_IDLE   : row return value with no key pressed
//   row_index() : active-low row vector -> row_idx, lowest index wins
//   col_pattern(): col_idx -> active-low strobe pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StAccept,
    StHeld
  } state_e;

  localparam logic [3:0] COL_0     = 4'b0111;
  localparam logic [3:0] COL_1     = 4'b1011;
  localparam logic [3:0] COL_2     = 4'b1101;
  localparam logic [3:0] COL_3     = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // row_idx 0 is row_n[3]; when several rows are low the lowest row_idx wins.
  function automatic logic [1:0] row_index(input logic [3:0] rows_n);
    if (!rows_n[3]) begin
      return 2'd0;
    end else if (!rows_n[2]) begin
      return 2'd1;
    end else if (!rows_n[1]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return COL_0;
      2'd1:    return COL_1;
      2'd2:    return COL_2;
      default: return COL_3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the 4 asynchronous keypad row returns.
//   clk_i : system clock
//   rst_i : synchronous active-high reset, flops go to all-ones (no key)
//   d_i   : asynchronous row returns, active-low
//   q_o   : synchronized row returns
module keypad_sync (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] s1_q;
  logic [3:0] s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 4'b1111;
      s2_q <= 4'b1111;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with debounce and a 4-digit shift-in entry register.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   row_n_i     : row returns, active-low, asynchronous
//   clr_i       : synchronous clear of num_o
//   col_n_o     : column strobes, active-low, exactly one low
//   key_valid_o : one-cycle pulse per accepted key
//   key_code_o  : code of last accepted key, {row_idx, col_idx}
//   num_o       : last four keys, newest in [3:0]
// Build option: define KEYPAD_BKSP_EN to make key F a backspace on num_o.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  row_n_i,
  input  logic        clr_i,
  output logic [3:0]  col_n_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic [15:0] num_o
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CNT);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CNT - 1);

  logic [3:0] row_s;

  keypad_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (row_n_i),
    .q_o   (row_s)
  );

  state_e           state_q, state_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       row_lat_q, row_lat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [15:0]      num_q, num_d;

  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_idx_d  = col_idx_q;
    row_lat_d  = row_lat_q;
    key_code_d = key_code_q;
    num_d      = num_q;

    unique case (state_q)
      StScan: begin
        if (scan_cnt_q == ScanLast) begin
          scan_cnt_d = '0;
          if (row_s != ROWS_IDLE) begin
            // col_idx_q stays put, so the column is frozen and doubles as the latch.
            row_lat_d = row_s;
            deb_cnt_d = '0;
            state_d   = StDebPress;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      StDebPress: begin
        if (row_s != row_lat_q) begin
          state_d    = StScan;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          // Load the code on entry so it is valid alongside the key_valid pulse.
          key_code_d = {row_index(row_lat_q), col_idx_q};
          state_d    = StAccept;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      StAccept: begin
`ifdef KEYPAD_BKSP_EN
        if (key_code_q == 4'hF) begin
          num_d = {4'h0, num_q[15:4]};
        end else begin
          num_d = {num_q[11:0], key_code_q};
        end
`else
        num_d = {num_q[11:0], key_code_q};
`endif
        deb_cnt_d = '0;
        state_d   = StHeld;
      end

      StHeld: begin
        if (row_s != ROWS_IDLE) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StScan;
          col_idx_d  = col_idx_q + 2'd1;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: state_d = StScan;
    endcase

    // Clear has priority over a coincident accept.
    if (clr_i) begin
      num_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StScan;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      row_lat_q  <= ROWS_IDLE;
      key_code_q <= 4'h0;
      num_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      col_idx_q  <= col_idx_d;
      row_lat_q  <= row_lat_d;
      key_code_q <= key_code_d;
      num_q      <= num_d;
    end
  end

  assign col_n_o     = col_pattern(col_idx_q);
  assign key_valid_o = (state_q == StAccept);
  assign key_code_o  = key_code_q;
  assign num_o       = num_q;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A small keypad model pulls a row low only while the pressed key's column is strobed.
module tb_hex_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        key_down = 1'b0;
  logic [3:0]  key = 4'h0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] num;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  typedef struct {
    logic [3:0]  key;
    bit          clr_before;
    bit          clr_at_acc;
    logic [15:0] exp_num;
  } vec_t;

  vec_t tbl [15];

  hex_keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .row_n_i     (row_n),
    .clr_i       (clr),
    .col_n_o     (col_n),
    .key_valid_o (key_valid),
    .key_code_o  (key_code),
    .num_o       (num)
  );

  always #5 clk = ~clk;

  // key = {row_idx, col_idx}; row_idx r drives row_n[3-r], col_idx c answers col_n[3-c].
  always_comb begin
    row_n = 4'hF;
    if (key_down && col_n[3 - int'(key[1:0])] == 1'b0) begin
      row_n[3 - int'(key[3:2])] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && key_valid) pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_pulse(output bit seen, output int cycles);
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (key_valid) begin
        seen   = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [3:0] pat);
    for (int i = 0; i < 40; i++) begin
      if (col_n == pat) break;
      @(negedge clk);
    end
    check("wait_col", col_n, pat);
  endtask

  initial begin
    logic [3:0] colseq [4];
    bit seen;
    int cyc;
    int p0;
    bit frozen_ok;

    colseq[0] = 4'b0111;
    colseq[1] = 4'b1011;
    colseq[2] = 4'b1101;
    colseq[3] = 4'b1110;

    tbl[0]  = '{4'h1, 1'b0, 1'b0, 16'h0001};
    tbl[1]  = '{4'h2, 1'b0, 1'b0, 16'h0012};
    tbl[2]  = '{4'h3, 1'b0, 1'b0, 16'h0123};
    tbl[3]  = '{4'h4, 1'b0, 1'b0, 16'h1234};
    tbl[4]  = '{4'hA, 1'b0, 1'b1, 16'h0000};
    tbl[5]  = '{4'h1, 1'b0, 1'b0, 16'h0001};
    tbl[6]  = '{4'h2, 1'b0, 1'b0, 16'h0012};
    tbl[7]  = '{4'h3, 1'b0, 1'b0, 16'h0123};
    tbl[8]  = '{4'h4, 1'b0, 1'b0, 16'h1234};
`ifdef KEYPAD_BKSP_EN
    tbl[9]  = '{4'hF, 1'b0, 1'b0, 16'h0123};
`else
    tbl[9]  = '{4'hF, 1'b0, 1'b0, 16'h234F};
`endif
    tbl[10] = '{4'h1, 1'b1, 1'b0, 16'h0001};
    tbl[11] = '{4'h2, 1'b0, 1'b0, 16'h0012};
    tbl[12] = '{4'h3, 1'b0, 1'b0, 16'h0123};
    tbl[13] = '{4'h4, 1'b0, 1'b0, 16'h1234};
    tbl[14] = '{4'h5, 1'b0, 1'b0, 16'h2345};

    // Reset and idle scan.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_key_code", key_code, 4'h0);
    check("reset_num", num, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      check("idle_col_n", col_n, colseq[(i / 4) % 4]);
      @(negedge clk);
    end
    check("idle_no_pulse", pulses, 0);

    // Key 6 (row 1, col 2): latency, frozen column while held, release debounce.
    wait_col(4'b1101);
    key = 4'h6;
    key_down = 1'b1;
    wait_pulse(seen, cyc);
    check("k6_pulse_seen", seen, 1'b1);
    check("k6_latency", cyc, 12);
    check("k6_code", key_code, 4'h6);
    frozen_ok = 1'b1;
    for (int i = cyc; i < 40; i++) begin
      @(negedge clk);
      if (col_n != 4'b1101) frozen_ok = 1'b0;
    end
    key_down = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (col_n != 4'b1101) frozen_ok = 1'b0;
    end
    check("k6_col_frozen", frozen_ok, 1'b1);
    @(negedge clk);
    check("k6_col_advance", col_n, 4'b1110);
    check("k6_one_pulse", pulses, 1);
    check("k6_num", num, 16'h0006);

    // Bounce: 5 low, 2 high, then stable, on key 1 (row 0, col 1).
    wait_col(4'b1011);
    key = 4'h1;
    key_down = 1'b1;
    repeat (5) @(negedge clk);
    key_down = 1'b0;
    repeat (2) @(negedge clk);
    key_down = 1'b1;
    check("bounce_no_early_pulse", pulses, 1);
    wait_pulse(seen, cyc);
    check("bounce_pulse_seen", seen, 1'b1);
    check("bounce_code", key_code, 4'h1);
    repeat (4) @(negedge clk);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_pulses", pulses, 2);
    check("bounce_num", num, 16'h0061);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_num", num, 16'h0000);

    // Table-driven key entry.
    for (int t = 0; t < 15; t++) begin
      if (tbl[t].clr_before) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      p0 = pulses;
      key = tbl[t].key;
      key_down = 1'b1;
      wait_pulse(seen, cyc);
      check($sformatf("vec%0d_pulse_seen", t), seen, 1'b1);
      check($sformatf("vec%0d_code", t), key_code, tbl[t].key);
      if (tbl[t].clr_at_acc) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check($sformatf("vec%0d_pulse_width", t), key_valid, 1'b0);
      repeat (3) @(negedge clk);
      key_down = 1'b0;
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_num", t), num, tbl[t].exp_num);
      check($sformatf("vec%0d_pulse_count", t), pulses - p0, 1);
      check($sformatf("vec%0d_code_held", t), key_code, tbl[t].key);
    end

    check("total_pulses", pulses, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Input-side counterpart to the 4-digit seven-segment driver.
- Scans a 4x4 hex keypad using active-low column strobes and active-low row returns, and debounces each press.
- Decodes each press to a 4-bit hex code and shifts it into a 16-bit entry register, `num`.
- `num` feeds the display's 16-bit `num` input directly, so the last four keys typed are shown.

Parameters:
- SCAN_DIV, 1000: clock cycles each column strobe stays active while idle-scanning (must be >= 4).
- DEBOUNCE_CNT, 20000: consecutive stable cycles required to accept a press or a release (must be >= 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- row_n  in  4  keypad row returns, active-low, asynchronous to clk.
- clr  in  1  synchronous clear of num.
- col_n  out  4  column strobes, active-low, exactly one bit low at all times.
- key_valid  out  1  one-cycle pulse per accepted key.
- key_code  out  4  code of the last accepted key; held until the next accepted key.
- num  out  16  entry register, newest digit in [3:0].

Behaviour:
- Reset values (on rst high at a clk edge): col_n=4'b0111, key_valid=0, key_code=0, num=0, state=SCAN, all counters and synchronizer flops cleared to their idle values (synchronizer to 4'b1111).
- Reset mid-operation aborts any debounce or held state immediately.
- Input synchronization: row_n passes through a 2-flop synchronizer (row_s). All decisions use row_s only.
- Column sequence: 0111 -> 1011 -> 1101 -> 1110 -> 0111, advancing every SCAN_DIV cycles, in SCAN state only.
- Index mapping:
  - col_idx 0..3 corresponds to col_n[3]..col_n[0] low.
  - row_idx 0..3 corresponds to row_s[3]..row_s[0] low.
  - key_code = {row_idx[1:0], col_idx[1:0]}.
- Multiple rows low: the lowest row_idx wins.
- States:
  - SCAN: rotate columns. In the last cycle of a column slot, if row_s != 4'b1111, latch col_idx and row_s, freeze col_n, go to DEB_PRESS. Otherwise advance the column.
  - DEB_PRESS: counter increments each cycle while row_s equals the latched value. Any mismatch -> SCAN with the column rotation resuming at the next column. Counter reaching DEBOUNCE_CNT-1 -> ACCEPT.
  - ACCEPT (1 cycle):
    - key_valid=1 and key_code updated.
    - num <= {num[11:0], code}.
    - Go to HELD.
  - HELD: col_n stays frozen. Counter increments while row_s==4'b1111 and resets to 0 on any low row. Counter reaching DEBOUNCE_CNT-1 -> SCAN at the next column.
- Held keys never auto-repeat.
- Latency: key_valid rises exactly 2 (sync) + DEBOUNCE_CNT + 1 cycles after a stable press is first presented on row_n during the active column slot's final cycle.
- clr: num <= 0 in that cycle. If clr coincides with ACCEPT, clr wins for num; key_valid and key_code still update.
- Pressing a key in a column other than the active one is ignored until that column is strobed.

Optional Feature:
- Macro: KEYPAD_BKSP_EN.
- Defined: key code 4'hF acts as backspace. On acceptance, num <= {4'h0, num[15:4]}; key_valid pulses and key_code=4'hF.
- Undefined: 4'hF shifts in like any other digit.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEB_PRESS, ACCEPT, HELD}.
  - column pattern constants COL_0..COL_3 (4'b0111..4'b1110).
  - ROWS_IDLE=4'b1111.
  - a function mapping a one-hot-low row vector to row_idx.
- Sub-module keypad_sync: 2-flop, 4-bit synchronizer with synchronous reset to all-ones.
- FSM, counters and entry register stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
- Reset, no keys -> col_n cycles 0111,1011,1101,1110 every 4 clk; key_valid never asserts; num=16'h0000.
- Hold the key at row_idx 1, col_idx 2 for 40 cycles while its column is active, then release -> exactly one key_valid pulse, key_code=4'h6, num=16'h0006; col_n frozen at 1101 until 8 idle cycles after release.
- Enter keys 1,2,3,4,5 in sequence -> num=16'h2345 after the fifth pulse; five key_valid pulses total.
- Bounce: assert a row for 5 cycles, release for 2, then assert stably -> no pulse from the first burst; one pulse after the stable 8-cycle window.
- Assert clr in the same cycle as ACCEPT for key 4'hA, with num=16'h1234 -> num=16'h0000, key_code=4'hA, key_valid=1.
- With KEYPAD_BKSP_EN defined: num=16'h1234, press key F -> num=16'h0123, key_code=4'hF. Without the macro -> num=16'h234F.
